// File: rtl/pipeline_stall_controller_pkg.sv
// Shared pipeline definitions: stall FSM encoding and the mult/div latency
// constant used by both the controller and the mult/div datapath.
package pipeline_stall_controller_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        LD_GUARD = 1'b1
    } stall_state_t;

    localparam int MULDIV_CYCLES_DEF = 32;
    localparam int MD_CNT_W_DEF      = 6;

endpackage

// File: rtl/pipeline_stall_controller_muldiv_busy_counter.sv
// Tracks the iterative mult/div unit: accepts a start from ID and holds
// MulDiv_Busy for MULDIV_CYCLES cycles, allowing a back-to-back restart.
module muldiv_busy_counter
    import pipeline_stall_controller_pkg::*;
#(
    parameter int MULDIV_CYCLES = MULDIV_CYCLES_DEF,
    parameter int CNT_W         = MD_CNT_W_DEF
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic start_req,
    input  logic branch_taken,
    input  logic ld_stall,
    output logic busy
);

    logic [CNT_W-1:0] md_cnt;
    logic             cnt_zero;
    logic             accept;

    assign cnt_zero = (md_cnt == '0);
    // A start squashed by a branch or held by a load-use bubble is retried later.
    assign accept   = start_req && !branch_taken && !ld_stall && (!busy || cnt_zero);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            md_cnt <= '0;
            busy   <= 1'b0;
        end else if (accept) begin
            md_cnt <= CNT_W'(MULDIV_CYCLES - 1);
            busy   <= 1'b1;
        end else if (busy) begin
            if (cnt_zero) begin
                busy <= 1'b0;
            end else begin
                md_cnt <= md_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// ID-stage stall consumer: turns load-use, mult/div and control-flow events
// into PC/IF/ID/ID/EX enables, bubbles and flushes, and counts stall cycles.
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int MULDIV_CYCLES = MULDIV_CYCLES_DEF,
    parameter int CNT_W         = MD_CNT_W_DEF
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Stall,
    input  logic        MulDiv_Start_ID,
    input  logic        HiLo_Read_ID,
    input  logic        Branch_Taken_EX,
    input  logic        Jump_ID,
    output logic        PC_Write,
    output logic        IFID_Write,
    output logic        IFID_Flush,
    output logic        IDEX_Bubble,
    output logic        IDEX_Flush,
    output logic        MulDiv_Busy,
    output logic [15:0] Stall_Count
);

    stall_state_t state_q, state_d;
    logic         ld_stall;
    logic         md_stall;

    // The upstream stall request is registered, so it lingers one extra cycle;
    // LD_GUARD swallows that echo to give exactly one bubble per hazard.
    assign ld_stall = (state_q == RUN) && Stall;
    assign md_stall = MulDiv_Busy && (HiLo_Read_ID || MulDiv_Start_ID);

    muldiv_busy_counter #(
        .MULDIV_CYCLES (MULDIV_CYCLES),
        .CNT_W         (CNT_W)
    ) u_md_cnt (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .start_req    (MulDiv_Start_ID),
        .branch_taken (Branch_Taken_EX),
        .ld_stall     (ld_stall),
        .busy         (MulDiv_Busy)
    );

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = (ld_stall && !Branch_Taken_EX) ? LD_GUARD : RUN;
        PC_Write    = 1'b1;
        IFID_Write  = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Flush  = 1'b0;
        IDEX_Bubble = 1'b0;
        if (!Reset_n) begin
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IFID_Flush  = 1'b1;
            IDEX_Flush  = 1'b1;
            IDEX_Bubble = 1'b1;
        end else if (Branch_Taken_EX) begin
            IFID_Flush  = 1'b1;
            IDEX_Flush  = 1'b1;
        end else if (ld_stall || md_stall) begin
            // A jump sitting in ID is held, not flushed, until the stall clears.
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
        end else if (Jump_ID) begin
            IFID_Flush  = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            Stall_Count <= '0;
        end else if (!PC_Write && (Stall_Count != 16'hFFFF)) begin
            Stall_Count <= Stall_Count + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench: the driver predicts each cycle from a cycle-indexed model,
// the monitor compares on the falling edge.
module tb_pipeline_stall_controller;

    localparam int MD = 4;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Stall = 1'b0;
    logic        MulDiv_Start_ID = 1'b0;
    logic        HiLo_Read_ID = 1'b0;
    logic        Branch_Taken_EX = 1'b0;
    logic        Jump_ID = 1'b0;
    logic        PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, IDEX_Flush;
    logic        MulDiv_Busy;
    logic [15:0] Stall_Count;

    pipeline_stall_controller #(.MULDIV_CYCLES(MD), .CNT_W(6)) dut (
        .Clk             (Clk),
        .Reset_n         (Reset_n),
        .Stall           (Stall),
        .MulDiv_Start_ID (MulDiv_Start_ID),
        .HiLo_Read_ID    (HiLo_Read_ID),
        .Branch_Taken_EX (Branch_Taken_EX),
        .Jump_ID         (Jump_ID),
        .PC_Write        (PC_Write),
        .IFID_Write      (IFID_Write),
        .IFID_Flush      (IFID_Flush),
        .IDEX_Bubble     (IDEX_Bubble),
        .IDEX_Flush      (IDEX_Flush),
        .MulDiv_Busy     (MulDiv_Busy),
        .Stall_Count     (Stall_Count)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [4:0]  ctl;      // {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, IDEX_Bubble}
        logic        busy;
        logic [15:0] cnt;
        bit          chk_regs;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Model state: cycle index, cycle of the last accepted mult/div start,
    // cycle of the last load-use bubble, and the stall-cycle tally.
    int cyc = 0;
    int acc_cyc = -1000;
    int last_ld = -1000;
    int cnt = 0;

    task automatic drive(input bit rst_n, input bit stl, input bit st,
                         input bit hl, input bit br, input bit jp);
        exp_t e;
        bit busy, guard, ld, md, last_md_cycle;
        @(posedge Clk);
        #1;
        Reset_n = rst_n; Stall = stl; MulDiv_Start_ID = st;
        HiLo_Read_ID = hl; Branch_Taken_EX = br; Jump_ID = jp;

        busy          = (cyc > acc_cyc) && (cyc <= acc_cyc + MD);
        last_md_cycle = (cyc == acc_cyc + MD);
        guard         = (cyc == last_ld + 1);
        ld            = stl && !guard;
        md            = busy && (hl || st);

        if (!rst_n)        e.ctl = 5'b00111;
        else if (br)       e.ctl = 5'b11110;
        else if (ld || md) e.ctl = 5'b00001;
        else if (jp)       e.ctl = 5'b11100;
        else               e.ctl = 5'b11000;
        e.busy     = busy;
        e.cnt      = cnt[15:0];
        e.chk_regs = (cyc > 0);
        e.cyc      = cyc;
        exp_q.push_back(e);

        if (!rst_n) begin
            acc_cyc = -1000; last_ld = -1000; cnt = 0;
        end else begin
            if (st && !br && !ld && (!busy || last_md_cycle)) acc_cyc = cyc;
            if (ld && !br) last_ld = cyc;
            if (!e.ctl[4] && cnt < 65535) cnt++;
        end
        cyc++;
    endtask

    initial begin
        exp_t e;
        logic [4:0] act;
        forever begin
            @(negedge Clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, IDEX_Bubble};
                checks++;
                if (act !== e.ctl ||
                    (e.chk_regs && (MulDiv_Busy !== e.busy || Stall_Count !== e.cnt))) begin
                    errors++;
                    $display("FAIL cycle%0d: got ctl=%b busy=%b cnt=%h, want ctl=%b busy=%b cnt=%h",
                             e.cyc, act, MulDiv_Busy, Stall_Count, e.ctl, e.busy, e.cnt);
                end
            end
        end
    end

    initial begin
        //        rst stl st hl br jp
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        // load-use: two-cycle registered request gives one bubble
        drive(1, 1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        // mult/div start then MFHI held until unit drains
        drive(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) drive(1, 0, 0, 1, 0, 0);
        // branch overrides stall and jump; stall honoured next cycle
        drive(1, 1, 0, 0, 1, 1);
        drive(1, 1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0);
        // jump held during md stall, flushes once busy drops
        drive(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) drive(1, 0, 0, 1, 0, 1);
        // reset mid mult/div abandons it
        drive(1, 0, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        drive(1, 0, 0, 1, 0, 0);
        drive(1, 0, 0, 1, 0, 0);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(99) != 0),
                  ($urandom_range(3) == 0),
                  ($urandom_range(6) == 0),
                  ($urandom_range(3) == 0),
                  ($urandom_range(9) == 0),
                  ($urandom_range(6) == 0));
        end
        // continuous start request keeps ID stalled: drives count to saturation
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 65540; i++) drive(1, 0, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge Clk);
        @(negedge Clk);
        if (exp_q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
